// File: rtl/smc_pkg.sv
// Shared types and defaults for the DE10-Lite memory sequencer labs.
// The RAM and display blocks pick up the same default widths from here.
package smc_pkg;

   localparam int DIV_W      = 26;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_RD   = 2'd2,
      S_CAP  = 2'd3
   } seq_state_t;

   // Fill pattern before truncation to the RAM word width.
   function automatic int unsigned init_word(input int unsigned addr, input int unsigned step);
      return addr * step;
   endfunction

endpackage

// File: rtl/smc_tick_div.sv
// Free-running clock divider producing a one-cycle tick every DIV enabled clocks.
// The count freezes (rather than clears) while enable is low.
module smc_tick_div
   import smc_pkg::*;
#(
   parameter int DIV = 25000000
) (
   input  logic             clk,
   input  logic             KEY0,
   input  logic             enable,
   output logic [DIV_W-1:0] divby,
   output logic             newgo
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   always_ff @(posedge clk or negedge KEY0) begin
      if (!KEY0) begin
         divby <= '0;
      end else if (enable) begin
         if (divby == LAST) begin
            divby <= '0;
         end else begin
            divby <= divby + DIV_W'(1);
         end
      end
   end

   // Gated by enable so a held divider can never emit a tick.
   assign newgo = enable && (divby == LAST);

endmodule

// File: rtl/smc_mem_sequencer.sv
// Fills the single-port RAM with a known pattern, then reads one word per divider tick
// and keeps a running sum and pass count for the HEX/LEDR display.
//
// state  | meaning
// S_INIT | writing the fill pattern, one address per clock
// S_IDLE | waiting for a tick; mem_addr parked on the read pointer
// S_RD   | RAM samples mem_addr on the closing edge
// S_CAP  | mem_rdata valid; capture into display, sum and pointer
module smc_mem_sequencer
   import smc_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DIV       = 25000000,
   parameter int INIT_STEP = 1,
   parameter int SUM_W     = ADDR_W + DATA_W
) (
   input  logic              MAX10_CLK1_50,
   input  logic              KEY0,
   input  logic              hold,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              newgo,
   output logic [DIV_W-1:0]  divby,
   output logic              init_done,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic [SUM_W-1:0]  sum,
   output logic [7:0]        pass_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   seq_state_t        state;
   logic [ADDR_W-1:0] init_addr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_ptr_next;
   logic              div_en;

   assign div_en      = init_done && !hold;
   assign rd_ptr_next = rd_ptr + ADDR_W'(1);

   smc_tick_div #(
      .DIV (DIV)
   ) u_tick_div (
      .clk    (MAX10_CLK1_50),
      .KEY0   (KEY0),
      .enable (div_en),
      .divby  (divby),
      .newgo  (newgo)
   );

   always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
      if (!KEY0) begin
         state     <= S_INIT;
         init_addr <= '0;
         rd_ptr    <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         init_done <= 1'b0;
         disp_addr <= '0;
         disp_data <= '0;
         sum       <= '0;
         pass_cnt  <= '0;
      end else begin
         case (state)
            S_INIT: begin
               // Leave once the last address has been presented for a full cycle.
               if (mem_we && (mem_addr == LAST_ADDR)) begin
                  state     <= S_IDLE;
                  mem_we    <= 1'b0;
                  mem_wdata <= '0;
                  mem_addr  <= '0;
                  rd_ptr    <= '0;
                  init_done <= 1'b1;
               end else begin
                  mem_we    <= 1'b1;
                  mem_addr  <= init_addr;
                  mem_wdata <= DATA_W'(init_word(32'(init_addr), unsigned'(INIT_STEP)));
                  init_addr <= init_addr + ADDR_W'(1);
               end
            end
            S_IDLE: begin
               mem_addr <= rd_ptr;
               if (newgo) begin
                  state <= S_RD;
               end
            end
            S_RD: begin
               state <= S_CAP;
            end
            S_CAP: begin
               disp_addr <= rd_ptr;
               disp_data <= mem_rdata;
               sum       <= sum + SUM_W'(mem_rdata);
               rd_ptr    <= rd_ptr_next;
               mem_addr  <= rd_ptr_next;
               if (rd_ptr == LAST_ADDR) begin
                  pass_cnt <= pass_cnt + 8'd1;
               end
               state <= S_IDLE;
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smc_mem_sequencer.sv
// Bench for smc_mem_sequencer: two instances (fill steps 3 and 255) on behavioural RAMs,
// checked every cycle against a tick/schedule model plus literal pass totals.
module tb_smc_mem_sequencer;

   localparam int AW    = 3;
   localparam int DW    = 8;
   localparam int DIVP  = 4;
   localparam int SW    = 11;
   localparam int NI    = 2;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic KEY0;
   logic hold;

   logic [AW-1:0] mem_addr  [NI];
   logic          mem_we    [NI];
   logic [DW-1:0] mem_wdata [NI];
   logic [DW-1:0] mem_rdata [NI];
   logic          newgo     [NI];
   logic [25:0]   divby     [NI];
   logic          init_done [NI];
   logic [AW-1:0] disp_addr [NI];
   logic [DW-1:0] disp_data [NI];
   logic [SW-1:0] sum       [NI];
   logic [7:0]    pass_cnt  [NI];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [DW-1:0] ram [DEPTH];
      logic [DW-1:0] rdata_q;

      smc_mem_sequencer #(
         .ADDR_W    (AW),
         .DATA_W    (DW),
         .DIV       (DIVP),
         .INIT_STEP (g == 0 ? 3 : 255),
         .SUM_W     (SW)
      ) u_dut (
         .MAX10_CLK1_50 (clk),
         .KEY0          (KEY0),
         .hold          (hold),
         .mem_addr      (mem_addr[g]),
         .mem_we        (mem_we[g]),
         .mem_wdata     (mem_wdata[g]),
         .mem_rdata     (mem_rdata[g]),
         .newgo         (newgo[g]),
         .divby         (divby[g]),
         .init_done     (init_done[g]),
         .disp_addr     (disp_addr[g]),
         .disp_data     (disp_data[g]),
         .sum           (sum[g]),
         .pass_cnt      (pass_cnt[g])
      );

      // Garbage power-up contents so the fill pattern has to be written to be seen.
      initial begin
         for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
      end

      always @(posedge clk) begin
         if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
         rdata_q <= ram[mem_addr[g]];
      end

      assign mem_rdata[g] = rdata_q;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int exp_word(input int g, input int a);
      return (a * (g == 0 ? 3 : 255)) % 256;
   endfunction

   // Model: k = clock edges since KEY0 release; INIT covers k=1..8, run from k=9.
   // A tick in cycle T schedules a capture visible in cycle T+3.
   int k        = 0;
   bit key_prev = 1'b0;
   int m_div, m_ptr, m_pass, m_daddr;
   int m_sum   [NI];
   int m_ddata [NI];
   int pend    [$];

   task automatic model_reset();
      m_div   = 0;
      m_ptr   = 0;
      m_pass  = 0;
      m_daddr = 0;
      for (int g = 0; g < NI; g++) begin
         m_sum[g]   = 0;
         m_ddata[g] = 0;
      end
      pend.delete();
   endtask

   initial model_reset();

   always @(negedge clk) begin
      bit exp_go;
      bit in_init;
      bit running;
      if (!KEY0) begin
         key_prev = 1'b0;
         k        = 0;
         model_reset();
      end else begin
         k        = key_prev ? k + 1 : 0;
         key_prev = 1'b1;
         while (pend.size() > 0 && pend[0] == k) begin
            void'(pend.pop_front());
            m_daddr = m_ptr;
            for (int g = 0; g < NI; g++) begin
               m_ddata[g] = exp_word(g, m_ptr);
               m_sum[g]   = (m_sum[g] + m_ddata[g]) % (1 << SW);
            end
            m_ptr = (m_ptr + 1) % DEPTH;
            if (m_ptr == 0) m_pass = (m_pass + 1) % 256;
         end
      end
      in_init = KEY0 && k >= 1 && k <= 8;
      running = KEY0 && k >= 9;
      exp_go  = running && !hold && m_div == DIVP - 1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("mem_we[%0d]", g), int'(mem_we[g]), int'(in_init));
         chk($sformatf("mem_addr[%0d]", g), int'(mem_addr[g]),
             in_init ? k - 1 : (running ? m_ptr : 0));
         if (!running)
            chk($sformatf("mem_wdata[%0d]", g), int'(mem_wdata[g]), in_init ? exp_word(g, k - 1) : 0);
         chk($sformatf("init_done[%0d]", g), int'(init_done[g]), int'(running));
         chk($sformatf("divby[%0d]", g), int'(divby[g]), m_div);
         chk($sformatf("newgo[%0d]", g), int'(newgo[g]), int'(exp_go));
         chk($sformatf("disp_addr[%0d]", g), int'(disp_addr[g]), m_daddr);
         chk($sformatf("disp_data[%0d]", g), int'(disp_data[g]), m_ddata[g]);
         chk($sformatf("sum[%0d]", g), int'(sum[g]), m_sum[g]);
         chk($sformatf("pass_cnt[%0d]", g), int'(pass_cnt[g]), m_pass);
      end
      if (newgo[0]) chk("tick_in_idle", pend.size(), 0);
      if (exp_go) pend.push_back(k + 3);
      if (running && !hold) m_div = (m_div + 1) % DIVP;
   end

   initial begin
      int t;
      int s0, s1, pa;
      KEY0 = 1'b0;
      hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sum", int'(sum[0]), 0);
      chk("rst_init_done", int'(init_done[0]), 0);
      chk("rst_mem_we", int'(mem_we[0]), 0);
      KEY0 = 1'b1;

      // Negedges from release until init_done: reset cycle plus 8 writes plus one.
      t = 0;
      while (!init_done[0] && t < 50) begin @(negedge clk); t++; end
      chk("init_latency", t, 10);

      t = 0;
      while (pass_cnt[0] != 8'd1 && t < 200) begin @(negedge clk); t++; end
      chk("pass1_reached", int'(t < 200), 1);
      chk("pass1_sum0", int'(sum[0]), 84);
      chk("pass1_disp_addr0", int'(disp_addr[0]), 7);
      chk("pass1_disp_data0", int'(disp_data[0]), 21);
      chk("pass1_sum1", int'(sum[1]), 1764);
      chk("pass1_disp_data1", int'(disp_data[1]), 249);

      t = 0;
      while (pass_cnt[1] != 8'd2 && t < 200) begin @(negedge clk); t++; end
      chk("pass2_reached", int'(t < 200), 1);
      chk("pass2_sum0", int'(sum[0]), 168);
      chk("pass2_sum1", int'(sum[1]), 1480);

      // Hold in S_IDLE with divby=2 for 10 cycles.
      t = 0;
      while (divby[0] != 26'd1 && t < 20) begin @(negedge clk); t++; end
      chk("hold_sync", int'(t < 20), 1);
      @(posedge clk); #1 hold = 1'b1;
      @(negedge clk);
      s0 = int'(sum[0]);
      s1 = int'(sum[1]);
      pa = int'(disp_addr[0]);
      repeat (10) @(posedge clk);
      #1 hold = 1'b0;
      @(negedge clk);
      chk("hold_divby", int'(divby[0]), 2);
      chk("hold_sum0", int'(sum[0]), s0);
      chk("hold_sum1", int'(sum[1]), s1);
      @(negedge clk);
      chk("hold_release_newgo", int'(newgo[0]), 1);
      repeat (3) @(negedge clk);
      chk("hold_ptr", int'(disp_addr[0]), (pa + 1) % DEPTH);

      repeat (400) begin
         @(posedge clk);
         #1 hold = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1 hold = 1'b0;

      // Reset dropped while a capture is in flight must clear outputs without a clock edge.
      t = 0;
      while (!newgo[0] && t < 100) begin @(negedge clk); t++; end
      chk("cap_sync", int'(t < 100), 1);
      @(posedge clk);
      @(posedge clk);
      #1 KEY0 = 1'b0;
      #1;
      chk("async_sum0", int'(sum[0]), 0);
      chk("async_sum1", int'(sum[1]), 0);
      chk("async_disp_data1", int'(disp_data[1]), 0);
      chk("async_pass_cnt", int'(pass_cnt[0]), 0);
      chk("async_init_done", int'(init_done[0]), 0);
      chk("async_divby", int'(divby[0]), 0);
      chk("async_mem_addr", int'(mem_addr[0]), 0);
      repeat (2) @(posedge clk);
      #1 KEY0 = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1 hold = 1'(($urandom_range(0, 1)));
      end
      @(posedge clk); #1 hold = 1'b0;
      repeat (80) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
